// File: rtl/vga_fb_write_arbiter.sv
// vga_fb_write_arbiter: sole owner of the 80x60 framebuffer write port.
// CPU pixel stores are queued in a small FIFO and have strict priority over
// a hardware rectangle-fill engine. Every write is a single-cycle FB_WE
// pulse, and consecutive pulses are at least WR_SPACING cycles apart.
module vga_fb_write_arbiter #(
  parameter int          FIFO_DEPTH    = 4,
  parameter int          WR_SPACING    = 2,
  parameter logic [31:0] VGA_ADDR_AD   = 32'h11100000,
  parameter logic [31:0] VGA_COLOR_AD  = 32'h11140000,
  parameter logic [31:0] VGA_READ_AD   = 32'h11040000,
  parameter logic [31:0] FILL_COLOR_AD = 32'h11180000,
  parameter logic [31:0] FILL_RECT_AD  = 32'h11180004,
  parameter logic [31:0] STATUS_AD     = 32'h11180008
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic [12:0] FB_WA,
  output logic [7:0]  FB_WD,
  output logic        FB_WE,
  input  logic [7:0]  FB_RD
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int SCW = (WR_SPACING > 1) ? $clog2(WR_SPACING) : 1;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_ent_t;

  typedef enum logic {S_IDLE, S_RUN} fill_st_t;

  // ---------------- registers ----------------
  logic [12:0]    r_cursor;
  logic [7:0]     r_fill_color;
  wr_ent_t        r_fifo [FIFO_DEPTH];
  logic [PW-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic [SCW-1:0] r_space_cnt;
  fill_st_t       r_state, w_state_nxt;
  logic [6:0]     r_fx, r_x0, r_x1;
  logic [5:0]     r_fy, r_y1;
  logic [7:0]     r_fill_wd;
  logic           r_ovf, r_rect_err;
  logic           r_fb_we;
  logic [12:0]    r_fb_wa;
  logic [7:0]     r_fb_wd;

  // ---------------- bus decode ----------------
  logic w_wr_addr, w_wr_color, w_wr_fcol, w_wr_rect, w_wr_status;
  assign w_wr_addr   = IOBUS_WR && (IOBUS_ADDR == VGA_ADDR_AD);
  assign w_wr_color  = IOBUS_WR && (IOBUS_ADDR == VGA_COLOR_AD);
  assign w_wr_fcol   = IOBUS_WR && (IOBUS_ADDR == FILL_COLOR_AD);
  assign w_wr_rect   = IOBUS_WR && (IOBUS_ADDR == FILL_RECT_AD);
  assign w_wr_status = IOBUS_WR && (IOBUS_ADDR == STATUS_AD);

  // ---------------- arbitration ----------------
  logic    w_ready, w_fifo_empty, w_fifo_full;
  logic    w_grant_cpu, w_grant_fill, w_push, w_drop;
  wr_ent_t w_head;
  assign w_ready      = (r_space_cnt == '0);
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_grant_cpu  = w_ready && !w_fifo_empty;
  assign w_grant_fill = w_ready && w_fifo_empty && (r_state == S_RUN);
  // a store into a full FIFO survives only if the head leaves this cycle
  assign w_push       = w_wr_color && (!w_fifo_full || w_grant_cpu);
  assign w_drop       = w_wr_color && w_fifo_full && !w_grant_cpu;

  // ---------------- rectangle command decode ----------------
  logic [6:0] w_rx0, w_rx1_raw, w_rx1;
  logic [5:0] w_ry0, w_ry1_raw, w_ry1;
  logic       w_rect_bad, w_start, w_busy_hit, w_rect_err_set, w_fill_last;
  assign w_rx0          = IOBUS_OUT[6:0];
  assign w_ry0          = IOBUS_OUT[13:8];
  assign w_rx1_raw      = IOBUS_OUT[22:16];
  assign w_ry1_raw      = IOBUS_OUT[29:24];
  assign w_rx1          = (w_rx1_raw > 7'd79) ? 7'd79 : w_rx1_raw;
  assign w_ry1          = (w_ry1_raw > 6'd59) ? 6'd59 : w_ry1_raw;
  assign w_rect_bad     = (w_rx0 > w_rx1) || (w_ry0 > w_ry1);
  assign w_start        = w_wr_rect && (r_state == S_IDLE) && !w_rect_bad;
  assign w_busy_hit     = w_wr_rect && (r_state == S_RUN);
  assign w_rect_err_set = w_wr_rect && (r_state == S_IDLE) && w_rect_bad;
  assign w_fill_last    = (r_fx == r_x1) && (r_fy == r_y1);

  // Fill FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Fill FSM next state: leave RUN once the last pixel is granted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_RUN;
      S_RUN:  if (w_grant_fill && w_fill_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fill pixel pointer: row-major walk, colour latched at start
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fx      <= '0;
      r_fy      <= '0;
      r_x0      <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_fill_wd <= '0;
    end else if (w_start) begin
      r_fx      <= w_rx0;
      r_fy      <= w_ry0;
      r_x0      <= w_rx0;
      r_x1      <= w_rx1;
      r_y1      <= w_ry1;
      r_fill_wd <= r_fill_color;
    end else if (w_grant_fill && !w_fill_last) begin
      if (r_fx == r_x1) begin
        r_fx <= r_x0;
        r_fy <= r_fy + 6'd1;
      end else begin
        r_fx <= r_fx + 7'd1;
      end
    end
  end

  // FIFO storage (no reset needed: validity tracked by r_count)
  always_ff @(posedge CLK) begin
    if (w_push) r_fifo[r_wr_ptr] <= '{addr: r_cursor, data: IOBUS_OUT[7:0]};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_grant_cpu) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_grant_cpu})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Spacing counter: after a grant, block the next WR_SPACING-1 cycles
  always_ff @(posedge CLK) begin
    if (RESET)                               r_space_cnt <= '0;
    else if (w_grant_cpu || w_grant_fill)    r_space_cnt <= SCW'(WR_SPACING - 1);
    else if (r_space_cnt != '0)              r_space_cnt <= r_space_cnt - 1'b1;
  end

  // Write port: one-cycle strobe; address parks on the cursor when idle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fb_we <= 1'b0;
      r_fb_wa <= '0;
      r_fb_wd <= '0;
    end else begin
      r_fb_we <= w_grant_cpu || w_grant_fill;
      if (w_grant_cpu) begin
        r_fb_wa <= w_head.addr;
        r_fb_wd <= w_head.data;
      end else if (w_grant_fill) begin
        r_fb_wa <= {r_fy, r_fx};
        r_fb_wd <= r_fill_wd;
      end else begin
        r_fb_wa <= r_cursor;
      end
    end
  end

  // Cursor and fill-colour registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cursor     <= '0;
      r_fill_color <= '0;
    end else begin
      if (w_wr_addr) r_cursor     <= IOBUS_OUT[12:0];
      if (w_wr_fcol) r_fill_color <= IOBUS_OUT[7:0];
    end
  end

  // Sticky status bits: set events take precedence over a clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ovf      <= 1'b0;
      r_rect_err <= 1'b0;
    end else begin
      if (w_drop || w_busy_hit) r_ovf <= 1'b1;
      else if (w_wr_status)     r_ovf <= 1'b0;
      if (w_rect_err_set)       r_rect_err <= 1'b1;
      else if (w_start)         r_rect_err <= 1'b0;
      else if (w_wr_status)     r_rect_err <= 1'b0;
    end
  end

  // Bus readback: zero outside own addresses so the wrapper can OR sources
  always_comb begin
    IOBUS_IN = '0;
    if (IOBUS_ADDR == STATUS_AD) begin
      IOBUS_IN[0]    = (r_state == S_RUN);
      IOBUS_IN[1]    = w_fifo_full;
      IOBUS_IN[2]    = w_fifo_empty;
      IOBUS_IN[3]    = r_rect_err;
      IOBUS_IN[4]    = r_ovf;
      IOBUS_IN[10:8] = 3'(r_count);
    end else if (IOBUS_ADDR == VGA_READ_AD) begin
      IOBUS_IN[7:0] = FB_RD;
    end
  end

  assign FB_WE = r_fb_we;
  assign FB_WA = r_fb_wa;
  assign FB_WD = r_fb_wd;

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Bench for vga_fb_write_arbiter: directed plus randomized IOBUS traffic,
// a transaction-level reference model and a scoreboard of expected writes.
module tb_vga_fb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int SP    = 2;
  localparam logic [31:0] ADDR_AD   = 32'h11100000;
  localparam logic [31:0] COLOR_AD  = 32'h11140000;
  localparam logic [31:0] READ_AD   = 32'h11040000;
  localparam logic [31:0] FCOL_AD   = 32'h11180000;
  localparam logic [31:0] RECT_AD   = 32'h11180004;
  localparam logic [31:0] STATUS_AD = 32'h11180008;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] IOBUS_ADDR = '0, IOBUS_OUT = '0, IOBUS_IN;
  logic        IOBUS_WR = 1'b0;
  logic [12:0] FB_WA;
  logic [7:0]  FB_WD, FB_RD;
  logic        FB_WE;

  vga_fb_write_arbiter #(.FIFO_DEPTH(DEPTH), .WR_SPACING(SP)) dut (
    .CLK(CLK), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .FB_WA(FB_WA), .FB_WD(FB_WD),
    .FB_WE(FB_WE), .FB_RD(FB_RD));

  always #5 CLK = ~CLK;

  // framebuffer memory behind the port
  logic [7:0] fbm [8192];
  initial for (int i = 0; i < 8192; i++) fbm[i] = 8'h00;
  always @(posedge CLK) if (FB_WE) fbm[FB_WA] <= FB_WD;
  assign FB_RD = fbm[FB_WA];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // ---------------- reference model ----------------
  typedef struct { logic [12:0] a; logic [7:0] d; int cyc; } exp_t;
  exp_t        scb[$];
  logic [20:0] cpu_q[$];
  logic [20:0] fill_q[$];
  logic [7:0]  mfb [8192];
  logic [12:0] m_cursor;
  logic [7:0]  m_fcol;
  logic        m_ovf, m_rerr;
  int          m_t = 0;
  int          next_slot = 0;

  initial for (int i = 0; i < 8192; i++) mfb[i] = 8'h00;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0]    = fill_q.size() > 0;
    s[1]    = cpu_q.size() == DEPTH;
    s[2]    = cpu_q.size() == 0;
    s[3]    = m_rerr;
    s[4]    = m_ovf;
    s[10:8] = 3'(cpu_q.size());
    return s;
  endfunction

  function automatic logic [31:0] rect(int x0, int y0, int x1, int y1);
    logic [31:0] r;
    r = '0;
    r[6:0]   = 7'(x0);
    r[13:8]  = 6'(y0);
    r[22:16] = 7'(x1);
    r[29:24] = 6'(y1);
    return r;
  endfunction

  // one clock edge of the model: port slot first, then the bus command
  task automatic mstep(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic rst);
    logic [20:0] e;
    logic        busy_pre, have;
    int          x0, y0, x1, y1;
    m_t++;
    if (rst) begin
      cpu_q.delete(); fill_q.delete();
      m_cursor = '0; m_fcol = '0; m_ovf = 0; m_rerr = 0; next_slot = 0;
      return;
    end
    busy_pre = fill_q.size() > 0;
    have = 0;
    e = '0;
    if (m_t >= next_slot) begin
      if (cpu_q.size() > 0) begin e = cpu_q.pop_front(); have = 1; end
      else if (fill_q.size() > 0) begin e = fill_q.pop_front(); have = 1; end
    end
    if (have) begin
      scb.push_back('{a: e[20:8], d: e[7:0], cyc: m_t});
      mfb[e[20:8]] = e[7:0];
      next_slot = m_t + SP;
    end
    if (wr) begin
      if (a == ADDR_AD) m_cursor = d[12:0];
      else if (a == COLOR_AD) begin
        if (cpu_q.size() < DEPTH) cpu_q.push_back({m_cursor, d[7:0]});
        else m_ovf = 1;
      end else if (a == FCOL_AD) m_fcol = d[7:0];
      else if (a == RECT_AD) begin
        x0 = int'(d[6:0]); y0 = int'(d[13:8]); x1 = int'(d[22:16]); y1 = int'(d[29:24]);
        if (x1 > 79) x1 = 79;
        if (y1 > 59) y1 = 59;
        if (busy_pre) m_ovf = 1;
        else if (x0 > x1 || y0 > y1) m_rerr = 1;
        else begin
          m_rerr = 0;
          for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
              fill_q.push_back({6'(y), 7'(x), m_fcol});
        end
      end else if (a == STATUS_AD) begin
        m_ovf = 0; m_rerr = 0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: every strobe must match the next scoreboard entry in cycle too
  always @(negedge CLK) begin
    exp_t e;
    if (FB_WE === 1'b1) begin
      checks++;
      if (scb.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got a=%h d=%h cyc=%0d expected none", FB_WA, FB_WD, edge_cnt);
      end else begin
        e = scb.pop_front();
        if (FB_WA !== e.a || FB_WD !== e.d || edge_cnt != e.cyc) begin
          errors++;
          $display("FAIL wr_seq got a=%h d=%h cyc=%0d expected a=%h d=%h cyc=%0d",
                   FB_WA, FB_WD, edge_cnt, e.a, e.d, e.cyc);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic rst);
    IOBUS_WR = wr; IOBUS_ADDR = a; IOBUS_OUT = d; RESET = rst;
    @(posedge CLK);
    mstep(wr, a, d, rst);
    @(negedge CLK);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, a, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic rd_status(input string nm);
    cycle(1'b0, STATUS_AD, 32'h0, 1'b0);
    chk(nm, IOBUS_IN, m_status());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((cpu_q.size() > 0 || fill_q.size() > 0) && n < 20000) begin
      idle(1);
      n++;
    end
    if (n >= 20000) chk("drain_timeout", 32'(n), 32'(0));
    idle(SP + 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] r;
    int op;
    int x0, y0;

    // reset
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("rst_we", 32'(FB_WE), 32'h0);
    chk("rst_wa", 32'(FB_WA), 32'h0);
    chk("rst_wd", 32'(FB_WD), 32'h0);
    chk("rst_other_addr", IOBUS_IN, 32'h0);
    rd_status("rst_status");
    chk("rst_status_const", IOBUS_IN, 32'h0000_0004);

    // single store: latency and readback
    wr(ADDR_AD, 32'h0105);
    wr(COLOR_AD, 32'h3C);
    drain();
    rd_status("single_status");
    cycle(1'b0, READ_AD, 32'h0, 1'b0);
    chk("readback_0105", IOBUS_IN, {24'h0, mfb[13'h0105]});
    chk("readback_0105_const", IOBUS_IN, 32'h0000_003C);

    // five back-to-back stores
    wr(ADDR_AD, 32'h0200);
    for (int i = 1; i <= 5; i++) wr(COLOR_AD, 32'(i));
    rd_status("burst5_status");
    drain();
    rd_status("burst5_after");

    // overflow, then clear
    for (int i = 0; i < 10; i++) wr(COLOR_AD, 32'(8'h40 + i));
    rd_status("ovf_status");
    chk("ovf_bit", 32'(IOBUS_IN[4]), 32'h1);
    wr(STATUS_AD, 32'h0);
    rd_status("ovf_cleared");
    drain();

    // small rectangle fill
    wr(FCOL_AD, 32'hE0);
    wr(RECT_AD, rect(2, 1, 4, 2));
    rd_status("fill_busy");
    chk("fill_busy_bit", 32'(IOBUS_IN[0]), 32'h1);
    drain();
    rd_status("fill_done");

    // CPU store interleaved in a 10x10 fill; also a start while busy
    wr(FCOL_AD, 32'h5A);
    wr(RECT_AD, rect(20, 20, 29, 29));
    idle(15);
    wr(ADDR_AD, 32'h0F0F);
    wr(COLOR_AD, 32'h77);
    wr(RECT_AD, rect(0, 0, 1, 1));
    rd_status("busy_hit_ovf");
    drain();
    wr(STATUS_AD, 32'h0);

    // invalid rectangle, then clamped rectangle
    wr(RECT_AD, rect(10, 0, 5, 3));
    rd_status("rect_err");
    chk("rect_err_bit", 32'(IOBUS_IN[3]), 32'h1);
    wr(RECT_AD, rect(78, 58, 127, 63));
    rd_status("clamp_start");
    drain();
    rd_status("clamp_done");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: wr(COLOR_AD, $urandom);
        4: wr(ADDR_AD, $urandom);
        5: wr(FCOL_AD, $urandom);
        6: begin
          x0 = $urandom_range(0, 81);
          y0 = $urandom_range(0, 61);
          wr(RECT_AD, rect(x0, y0, x0 + $urandom_range(0, 4) - 1, y0 + $urandom_range(0, 3) - 1));
        end
        7: wr(STATUS_AD, $urandom);
        8: rd_status("rand_status");
        default: idle(1);
      endcase
    end
    drain();
    rd_status("rand_end");
    cycle(1'b0, READ_AD, 32'h0, 1'b0);
    r = {24'h0, mfb[m_cursor]};
    chk("rand_readback", IOBUS_IN, r);

    // reset in the middle of a full-screen fill
    wr(FCOL_AD, 32'hC3);
    wr(RECT_AD, rect(0, 0, 79, 59));
    idle(40);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("midfill_rst_we", 32'(FB_WE), 32'h0);
    rd_status("midfill_rst_status");
    chk("midfill_rst_busy", 32'(IOBUS_IN[0]), 32'h0);
    idle(10);

    chk("scb_empty", 32'(scb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
